// File: rtl/tick_gen_multi_pkg.sv
// Shared types and constants for the multi-channel tick generator.
//   ch_state_t  : per-channel FSM state
//   DEFAULT_N_C : period loaded into every channel at reset
//   ch_w()      : channel-select width, never below 1
package tick_gen_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} ch_state_t;

  localparam int DEFAULT_N_C = 654;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tick_gen_multi_if.sv
// Config write port: valid/ready handshake carrying target channel and period.
//   cfg_valid  : write request
//   cfg_ch     : target channel
//   cfg_period : new period value
//   cfg_ready  : write accepted when valid & ready at the clock edge
interface tick_gen_multi_if #(
  parameter int CNT_W  = 16,
  parameter int NUM_CH = 4
);
  import tick_gen_pkg::*;
  localparam int CH_W = ch_w(NUM_CH);

  logic             cfg_valid;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic             cfg_ready;

  modport master (output cfg_valid, cfg_ch, cfg_period, input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_ch, cfg_period, output cfg_ready);
endinterface

// File: rtl/tick_gen_multi_ch.sv
// One tick channel: FSM, down-counter, active period, shadow period, pending flag.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : run enable (low = idle, counter reloaded)
//   i_oneshot      : sampled at the reload point, 1 = stop in DONE
//   i_wr           : accepted config write for this channel
//   i_wr_period    : period carried by the write
//   o_pending      : shadow holds a period not yet applied
//   o_tick         : registered one-cycle tick
//   o_busy         : channel in COUNT
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DEFAULT_N = DEFAULT_N_C
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_oneshot,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_period,
  output logic             o_pending,
  output logic             o_tick,
  output logic             o_busy
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_N);

  ch_state_t        r_state,  w_state_nx;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nx;
  logic [CNT_W-1:0] r_period, w_period_nx;
  logic [CNT_W-1:0] r_shadow, w_shadow_nx;
  logic             r_pending, w_pending_nx;
  logic             r_tick,    w_tick_nx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= DEF;
      r_period  <= DEF;
      r_shadow  <= DEF;
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_period  <= w_period_nx;
      r_shadow  <= w_shadow_nx;
      r_pending <= w_pending_nx;
      r_tick    <= w_tick_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_period_nx  = r_period;
    w_shadow_nx  = r_shadow;
    w_pending_nx = r_pending;
    w_tick_nx    = 1'b0;
    if (!i_en) begin
      // Disable beats everything, including a tick due on this edge.
      w_state_nx   = IDLE;
      w_cnt_nx     = r_shadow;
      w_period_nx  = r_shadow;
      w_pending_nx = 1'b0;
    end else if (r_state != DONE) begin
      // The edge that first sees en in IDLE already counts as an enabled clock,
      // so the first tick lands period edges after it.
      if (r_cnt != '0) begin
        w_cnt_nx   = r_cnt - CNT_W'(1);
        w_state_nx = COUNT;
      end else begin
        w_tick_nx    = 1'b1;
        w_period_nx  = r_shadow;
        w_cnt_nx     = r_shadow;
        w_pending_nx = 1'b0;
        w_state_nx   = i_oneshot ? DONE : COUNT;
      end
    end
    // A write only lands while not pending, so it never races a reload of
    // a pending value; it must win over the idle clear to hold ready low.
    if (i_wr) begin
      w_shadow_nx  = i_wr_period;
      w_pending_nx = 1'b1;
    end
  end

  assign o_pending = r_pending;
  assign o_tick    = r_tick;
  assign o_busy    = (r_state == COUNT);
endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : per-channel run enable
//   i_oneshot      : per-channel mode, 1 = single tick then hold
//   cfg            : config write port (slave)
//   o_tick         : per-channel one-cycle tick
//   o_busy         : per-channel COUNT indicator
//   o_any_tick     : OR of o_tick
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int NUM_CH    = 4,
  parameter int DEFAULT_N = DEFAULT_N_C
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_en,
  input  logic [NUM_CH-1:0] i_oneshot,
  tick_gen_multi_if.slave   cfg,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_busy,
  output logic              o_any_tick
);
  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_wr;
  logic              w_sel_pending;

  // Out-of-range channel matches nothing: ready stays high, write dropped.
  always_comb begin
    w_sel_pending = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (cfg.cfg_ch == CH_W'(c)) w_sel_pending = w_pending[c];
  end

  assign cfg.cfg_ready = !w_sel_pending;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr[g] = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_ch == CH_W'(g));

    tick_gen_ch #(.CNT_W(CNT_W), .DEFAULT_N(DEFAULT_N)) u_ch (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_en        (i_en[g]),
      .i_oneshot   (i_oneshot[g]),
      .i_wr        (w_wr[g]),
      .i_wr_period (cfg.cfg_period),
      .o_pending   (w_pending[g]),
      .o_tick      (o_tick[g]),
      .o_busy      (o_busy[g])
    );
  end

  assign o_any_tick = |o_tick;
endmodule

// File: tb/tb_tick_gen_multi.sv
module tb_tick_gen_multi;
  localparam int CNT_W  = 16;
  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] en, oneshot;
  logic [NUM_CH-1:0] tick, busy;
  logic              any_tick;

  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int unsigned exp_q [NUM_CH][$];

  tick_gen_multi_if #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) cfg_if ();

  tick_gen_multi #(.CNT_W(CNT_W), .NUM_CH(NUM_CH), .DEFAULT_N(654)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_oneshot  (oneshot),
    .cfg        (cfg_if),
    .o_tick     (tick),
    .o_busy     (busy),
    .o_any_tick (any_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int unsigned v);
    exp_q[c].push_back(v);
  endtask

  task automatic cfg_write(input int c, input int p);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = 2'(c);
    cfg_if.cfg_period = 16'(p);
    step(1);
    cfg_if.cfg_valid  = 1'b0;
    step(1);
  endtask

  // Scoreboard: every observed tick pops that channel's next expected cycle.
  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (tick[c] === 1'b1) begin
        if (exp_q[c].size() == 0)
          chk($sformatf("tick%0d_unexpected", c), cyc, 32'hFFFF_FFFF);
        else
          chk($sformatf("tick%0d_cycle", c), cyc, exp_q[c].pop_front());
      end
    end
    if (tick !== '0) chk("any_tick", {31'd0, any_tick}, 32'd1);
  end

  initial begin
    int unsigned b;

    rst_n = 1'b0; en = '0; oneshot = '0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_period = '0;
    #2;
    chk("rst_tick", {28'd0, tick}, 32'd0);
    chk("rst_busy", {28'd0, busy}, 32'd0);
    chk("rst_any",  {31'd0, any_tick}, 32'd0);
    chk("rst_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
    step(3);
    rst_n = 1'b1;
    step(1);

    // ch0 default period, periodic
    b = cyc; en[0] = 1'b1;
    for (int k = 1; k <= 3; k++) push(0, b + 655 * k);
    step(2);
    chk("ch0_busy", {31'd0, busy[0]}, 32'd1);
    step(1965);
    en[0] = 1'b0;
    step(2);
    chk("ch0_missed", exp_q[0].size(), 32'd0);
    chk("ch0_idle_busy", {31'd0, busy[0]}, 32'd0);

    // ch1 period 3 written while idle
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd1; cfg_if.cfg_period = 16'd3;
    chk("ch1_rdy_idle", {31'd0, cfg_if.cfg_ready}, 32'd1);
    step(1);
    cfg_if.cfg_valid = 1'b0;
    chk("ch1_rdy_pend", {31'd0, cfg_if.cfg_ready}, 32'd0);
    step(1);
    chk("ch1_rdy_back", {31'd0, cfg_if.cfg_ready}, 32'd1);
    b = cyc; en[1] = 1'b1;
    push(1, b + 4); push(1, b + 8); push(1, b + 12);
    step(14);
    en[1] = 1'b0;
    step(1);
    chk("ch1_missed", exp_q[1].size(), 32'd0);

    // ch2 running at 9, rewritten to 2 mid-count
    cfg_write(2, 9);
    b = cyc; en[2] = 1'b1;
    push(2, b + 10); push(2, b + 13); push(2, b + 16);
    step(4);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd2; cfg_if.cfg_period = 16'd2;
    chk("ch2_rdy_c4", {31'd0, cfg_if.cfg_ready}, 32'd1);
    step(1);
    cfg_if.cfg_valid = 1'b0;
    chk("ch2_rdy_c5", {31'd0, cfg_if.cfg_ready}, 32'd0);
    step(4);
    chk("ch2_rdy_c9", {31'd0, cfg_if.cfg_ready}, 32'd0);
    step(1);
    chk("ch2_rdy_c10", {31'd0, cfg_if.cfg_ready}, 32'd1);
    step(7);
    en[2] = 1'b0;
    step(1);
    chk("ch2_missed", exp_q[2].size(), 32'd0);

    // ch3 one-shot period 4, then re-armed by toggling en
    cfg_write(3, 4);
    b = cyc; oneshot[3] = 1'b1; en[3] = 1'b1;
    push(3, b + 5);
    step(2);
    chk("ch3_busy_run", {31'd0, busy[3]}, 32'd1);
    step(4);
    chk("ch3_busy_done", {31'd0, busy[3]}, 32'd0);
    step(9);
    en[3] = 1'b0;
    step(2);
    b = cyc; en[3] = 1'b1;
    push(3, b + 5);
    step(7);
    chk("ch3_missed", exp_q[3].size(), 32'd0);
    en[3] = 1'b0; oneshot[3] = 1'b0;
    step(1);

    // ch1 period 0: continuous ticks, none after en drops
    cfg_write(1, 0);
    b = cyc; en[1] = 1'b1;
    for (int k = 1; k <= 6; k++) push(1, b + k);
    step(6);
    en[1] = 1'b0;
    step(3);
    chk("ch1_p0_missed", exp_q[1].size(), 32'd0);

    // ch0 dropped mid-count must restart from a full period
    en[0] = 1'b1;
    step(100);
    en[0] = 1'b0;
    step(3);
    chk("ch0_drop_busy", {31'd0, busy[0]}, 32'd0);
    b = cyc; en[0] = 1'b1;
    push(0, b + 655);
    step(656);
    chk("ch0_reload_missed", exp_q[0].size(), 32'd0);
    en[0] = 1'b0;
    step(1);

    // all channels running, then async reset mid-count
    cfg_write(1, 5);
    b = cyc; en = '1;
    push(1, b + 6); push(1, b + 12);
    for (int k = 1; k <= 4; k++) push(2, b + 3 * k);
    push(3, b + 5); push(3, b + 10);
    step(13);
    chk("all_busy", {28'd0, busy}, 32'hF);
    rst_n = 1'b0;
    #1;
    chk("arst_tick", {28'd0, tick}, 32'd0);
    chk("arst_busy", {28'd0, busy}, 32'd0);
    chk("arst_any",  {31'd0, any_tick}, 32'd0);
    en = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
    cfg_if.cfg_ch = 2'd1;
    chk("arst_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
    for (int c = 0; c < NUM_CH; c++)
      chk($sformatf("pre_rst_missed%0d", c), exp_q[c].size(), 32'd0);
    b = cyc; en[1] = 1'b1;
    push(1, b + 655);
    step(656);
    chk("ch1_default_missed", exp_q[1].size(), 32'd0);
    en = '0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
